montgomery_precompute: RTL and testbench
========================================

# montgomery_precompute

Computes the Montgomery constants R mod m and R² mod m, with R = 2^WIDTH, for a given modulus. It sits directly upstream of `exponentiation` and drives that block's `Rmodm` and `Rsquaredmodm` inputs, so software no longer supplies them. The block uses iterative modular doubling, one doubling per cycle. Both constants come from a single 2·WIDTH-iteration run.

## Interface
- `WIDTH`, default 512: operand width in bits; R = 2^WIDTH.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `modulus`  in  WIDTH  modulus m; sampled on the accepted `start` edge only.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE; results valid.
- `invalid`  out  1  valid with `done`; high if the latched m is even or m ≤ 1.
- `Rmodm`  out  WIDTH  2^WIDTH mod m.
- `Rsquaredmodm`  out  WIDTH  2^(2·WIDTH) mod m.

## Operation
- Reset and internal registers:
  - Reset to IDLE.
  - Internal registers: `m_q` (WIDTH), `v` (WIDTH), `cnt` (log2(2·WIDTH)+1 bits).
- States: IDLE → RUN → DONE → IDLE.
- IDLE, `start`=1:
  - m_q ← modulus.
  - v ← (modulus==1) ? 0 : 1.
  - cnt ← 0.
  - invalid ← ~modulus[0] | (modulus ≤ 1).
  - → RUN.
- RUN, each cycle:
  - v ← dbl(v), where dbl(v) = t ≥ m_q ? t − m_q : t, and t = {v,1'b0} is WIDTH+1 bits.
  - Invariant: v < m_q, so one conditional subtract suffices.
  - cnt ← cnt+1.
- Capture points:
  - When cnt == WIDTH−1 (the WIDTH-th doubling): Rmodm ← dbl(v).
  - When cnt == 2·WIDTH−1: Rsquaredmodm ← dbl(v), → DONE.
- DONE:
  - `done`=1.
  - Outputs hold.
  - → IDLE when `start`=0; no retrigger while `start` stays high.
- Arithmetic is unsigned throughout.
- The subtraction compares the full WIDTH+1-bit t, so the carry-out is never dropped.
- Invalid moduli:
  - Even m and m ≤ 1 are still processed by the same algorithm.
  - `invalid` only flags them; downstream Montgomery logic requires odd m.
  - m==0 produces an undefined value, with `invalid`=1.
- `start` during RUN or DONE is ignored; `modulus` changes after acceptance are ignored.

## Timing
- Reset values:
  - `busy`, `done`, `invalid` = 0.
  - `Rmodm`, `Rsquaredmodm` = 0.
  - State IDLE.
- Reset asserted mid-run aborts immediately, with the same values as above.
- Latency, with edge 0 being the edge that samples `start`:
  - `busy` is high after edge 0.
  - `Rmodm` is valid after edge WIDTH.
  - `done` rises after edge 2·WIDTH, i.e. 1024 cycles at WIDTH=512.
- `Rmodm` is updated at edge WIDTH but `done` does not rise until edge 2·WIDTH; downstream must wait for `done`.
- Outputs remain stable from `done` until the next accepted `start`.
- New start timing:
  - Earliest new start is accepted on the edge after the one where DONE sees `start`=0.
  - Minimum inter-job gap: 2·WIDTH+2 cycles.
- Critical path: one WIDTH+1-bit subtract plus a mux, per cycle.

## Structure
- Shared package `montgomery_pkg`:
  - `WIDTH` default (512).
  - State enum {IDLE, RUN, DONE}.
  - Counter width function clog2(2·WIDTH)+1.
- Sub-module `mod_double_step`:
  - Combinational dbl(v, m).
  - WIDTH-parameterised.
  - Reusable by the exponentiation datapath.
- Top level: FSM, counter, registers, capture logic.

## Test plan
- WIDTH=512, m=ba3e64477e930dcc5ebcfd28c2d12d122208ae0edaf47fed345d17b62405c20c7eb9a0ca6396f35db871a75f05e43d3b3f771c3f4eba864e3106f880acbb31d3:
  - Rmodm=45c19bb8816cf233a14302d73d2ed2edddf751f1250b8012cba2e849dbfa3df381465f359c690ca2478e58a0fa1bc2c4c088e3c0b14579b1cef9077f5344ce2d.
  - Rsquaredmodm=7a07c54ae634d17d06bed9332932823257bb73745a0be9453069a22c45bcc3db2342077752bb20d9d3e82cc26de56f89247d6b24e696661ee4225dcd3a4465c5.
  - `done` after exactly 1024 cycles; `invalid`=0.
- WIDTH=8, m=13 → Rmodm=9, Rsquaredmodm=3, `done` after 16 cycles; m=3 at WIDTH=512 → both results 1.
- m=1 → both results 0, `invalid`=1; m=0x10 at WIDTH=8 → `invalid`=1, done still asserted after 16 cycles.
- `start` held high through DONE → `done` stays high, no second run; drop `start` then raise it with m=13 → new run, `busy` 1 cycle after.
- `resetn` low at cycle 300 of a run → all outputs 0 immediately; a subsequent start with m=13 gives 9 and 3.
- `modulus` changed and `start` pulsed during RUN → results still match the originally latched m.

Source files
------------

// File: rtl/montgomery_pkg.sv
// Shared types and sizing helpers for the Montgomery constant precompute block.
// The exponentiation datapath imports this package as well.
package montgomery_pkg;

    localparam int WIDTH_DEFAULT = 512;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // The counter must reach 2*WIDTH-1; one spare bit keeps the compare wrap-free.
    function automatic int cntWidth(input int width);
        return $clog2(2 * width) + 1;
    endfunction

endpackage

// File: rtl/mod_double_step.sv
// Combinational modular doubling: returns (2*v) mod m, assuming v < m.
// The compare uses the full WIDTH+1-bit doubled value so the carry-out is never lost.
module mod_double_step #(
    parameter int WIDTH = 512
) (
    input  logic [WIDTH-1:0] v_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] dbl_o
);

    logic [WIDTH:0] doubled;
    logic [WIDTH:0] reduced;
    logic [WIDTH:0] selected;
    logic           unused_msb;

    assign doubled  = {v_i, 1'b0};
    assign reduced  = doubled - {1'b0, m_i};
    assign selected = (doubled >= {1'b0, m_i}) ? reduced : doubled;

    // With v < m the selected value is below m, so its top bit is always zero.
    assign unused_msb = selected[WIDTH];
    assign dbl_o      = selected[WIDTH-1:0];

endmodule

// File: rtl/montgomery_precompute.sv
// Computes R mod m and R^2 mod m (R = 2^WIDTH) by repeated modular doubling,
// one doubling per cycle, capturing both constants from a single 2*WIDTH-step run.
module montgomery_precompute
    import montgomery_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             invalid,
    output logic [WIDTH-1:0] Rmodm,
    output logic [WIDTH-1:0] Rsquaredmodm
);

    localparam int             CW      = cntWidth(WIDTH);
    localparam logic [CW-1:0]  CAP_R   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CAP_RR  = CW'(2 * WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             invalid_q, invalid_d;
    logic [WIDTH-1:0] rmodm_q, rmodm_d;
    logic [WIDTH-1:0] rsqmodm_q, rsqmodm_d;
    logic [WIDTH-1:0] vDbl;

    mod_double_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .v_i   (v_q),
        .m_i   (m_q),
        .dbl_o (vDbl)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            m_q       <= '0;
            v_q       <= '0;
            cnt_q     <= '0;
            invalid_q <= 1'b0;
            rmodm_q   <= '0;
            rsqmodm_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            invalid_q <= invalid_d;
            rmodm_q   <= rmodm_d;
            rsqmodm_q <= rsqmodm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        v_d       = v_q;
        cnt_d     = cnt_q;
        invalid_d = invalid_q;
        rmodm_d   = rmodm_q;
        rsqmodm_d = rsqmodm_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d       = modulus;
                    // m == 1 must yield 0; seeding v with 0 keeps v < m for that case.
                    v_d       = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                    cnt_d     = '0;
                    invalid_d = ~modulus[0] | (modulus <= WIDTH'(1));
                    state_d   = RUN;
                end
            end
            RUN: begin
                v_d   = vDbl;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CAP_R) begin
                    rmodm_d = vDbl;
                end
                if (cnt_q == CAP_RR) begin
                    rsqmodm_d = vDbl;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign invalid      = invalid_q;
    assign Rmodm        = rmodm_q;
    assign Rsquaredmodm = rsqmodm_q;

endmodule

// File: tb/tb_montgomery_precompute.sv
// Self-checking bench for montgomery_precompute at WIDTH=8 and WIDTH=512, using a
// wide-integer reference (2^e mod m computed directly with the % operator).
module tb_montgomery_precompute;

    logic         clk;
    logic         resetn;

    logic         start8;
    logic [7:0]   mod8;
    logic         busy8, done8, inv8;
    logic [7:0]   rm8, rr8;

    logic         start512;
    logic [511:0] mod512;
    logic         busy512, done512, inv512;
    logic [511:0] rm512, rr512;

    int compareCount;
    int mismatchCount;

    montgomery_precompute #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start8),
        .modulus      (mod8),
        .busy         (busy8),
        .done         (done8),
        .invalid      (inv8),
        .Rmodm        (rm8),
        .Rsquaredmodm (rr8)
    );

    montgomery_precompute #(.WIDTH(512)) dut512 (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start512),
        .modulus      (mod512),
        .busy         (busy512),
        .done         (done512),
        .invalid      (inv512),
        .Rmodm        (rm512),
        .Rsquaredmodm (rr512)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: 2^e mod m straight from integer arithmetic.
    function automatic logic [511:0] powMod(input int e, input logic [511:0] m);
        logic [1024:0] big;
        logic [1024:0] mm;
        logic [1024:0] r;
        if (m == '0) return '0;
        big    = '0;
        big[e] = 1'b1;
        mm     = {513'b0, m};
        r      = big % mm;
        return r[511:0];
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic applyStimulus8(input logic [7:0] m, input bit holdStart);
        int         n;
        logic [511:0] tmp;
        logic [7:0] expR, expRR;
        logic       expInv;
        tmp    = powMod(8, {504'b0, m});
        expR   = tmp[7:0];
        tmp    = powMod(16, {504'b0, m});
        expRR  = tmp[7:0];
        expInv = (m[0] == 1'b0) || (m <= 8'd1);
        @(negedge clk);
        start8 = 1'b1;
        mod8   = m;
        @(negedge clk);
        if (!holdStart) start8 = 1'b0;
        mod8 = 8'($urandom);
        n = 0;
        checkOutput("busy8_after_edge0", 512'(busy8), 512'(1));
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 8 && m != 8'd0) checkOutput("rmodm8_at_edge_w", 512'(rm8), 512'(expR));
            if (n == 5 && !holdStart) begin
                start8 = 1'b1;
                mod8   = 8'($urandom);
            end
            if (n == 6 && !holdStart) start8 = 1'b0;
        end
        checkOutput("cycles8", 512'(n), 512'(16));
        checkOutput("done8", 512'(done8), 512'(1));
        checkOutput("busy8_in_done", 512'(busy8), 512'(0));
        checkOutput("invalid8", 512'(inv8), 512'(expInv));
        if (m != 8'd0) begin
            checkOutput("rmodm8", 512'(rm8), 512'(expR));
            checkOutput("rsqmodm8", 512'(rr8), 512'(expRR));
        end
    endtask

    task automatic applyStimulus512(input logic [511:0] m);
        int           n;
        logic [511:0] expR, expRR;
        logic         expInv;
        expR   = powMod(512, m);
        expRR  = powMod(1024, m);
        expInv = (m[0] == 1'b0) || (m <= 512'd1);
        @(negedge clk);
        start512 = 1'b1;
        mod512   = m;
        @(negedge clk);
        start512 = 1'b0;
        mod512   = rand512();
        n = 0;
        checkOutput("busy512_after_edge0", 512'(busy512), 512'(1));
        while (!done512 && n < 1100) begin
            @(negedge clk);
            n++;
            if (n == 512) checkOutput("rmodm512_at_edge_w", rm512, expR);
            if (n == 100) begin
                start512 = 1'b1;
                mod512   = rand512();
            end
            if (n == 101) start512 = 1'b0;
        end
        checkOutput("cycles512", 512'(n), 512'(1024));
        checkOutput("done512", 512'(done512), 512'(1));
        checkOutput("invalid512", 512'(inv512), 512'(expInv));
        checkOutput("rmodm512", rm512, expR);
        checkOutput("rsqmodm512", rr512, expRR);
    endtask

    initial begin
        logic [511:0] m;
        compareCount  = 0;
        mismatchCount = 0;
        resetn   = 1'b0;
        start8   = 1'b0;
        mod8     = '0;
        start512 = 1'b0;
        mod512   = '0;
        #1;
        checkOutput("reset_busy", 512'(busy8), 512'(0));
        checkOutput("reset_done", 512'(done512), 512'(0));
        checkOutput("reset_invalid", 512'(inv8), 512'(0));
        checkOutput("reset_rmodm", rm512, '0);
        checkOutput("reset_rsq", 512'(rr8), '0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Known vectors and boundary moduli at WIDTH=8.
        applyStimulus8(8'd13, 1'b0);
        checkOutput("m13_rmodm_const", 512'(rm8), 512'(9));
        checkOutput("m13_rsq_const", 512'(rr8), 512'(3));
        applyStimulus8(8'd1, 1'b0);
        applyStimulus8(8'h10, 1'b0);
        applyStimulus8(8'd0, 1'b0);
        applyStimulus8(8'd255, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus8(8'($urandom_range(2, 255)), 1'b0);

        // Start held high through DONE: no retrigger, then a clean restart.
        applyStimulus8(8'd13, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("hold_done_stays", 512'(done8), 512'(1));
        checkOutput("hold_no_rerun", 512'(busy8), 512'(0));
        start8 = 1'b0;
        @(negedge clk);
        checkOutput("hold_released_idle", 512'(done8), 512'(0));
        checkOutput("hold_outputs_stable", 512'(rm8), 512'(9));
        applyStimulus8(8'd13, 1'b0);

        // WIDTH=512 vectors.
        applyStimulus512(512'hba3e64477e930dcc5ebcfd28c2d12d122208ae0edaf47fed345d17b62405c20c7eb9a0ca6396f35db871a75f05e43d3b3f771c3f4eba864e3106f880acbb31d3);
        checkOutput("vec_rmodm_const", rm512,
            512'h45c19bb8816cf233a14302d73d2ed2edddf751f1250b8012cba2e849dbfa3df381465f359c690ca2478e58a0fa1bc2c4c088e3c0b14579b1cef9077f5344ce2d);
        checkOutput("vec_rsq_const", rr512,
            512'h7a07c54ae634d17d06bed9332932823257bb73745a0be9453069a22c45bcc3db2342077752bb20d9d3e82cc26de56f89247d6b24e696661ee4225dcd3a4465c5);
        applyStimulus512(512'd3);
        checkOutput("m3_rmodm_const", rm512, 512'd1);
        applyStimulus512(512'd1);
        m = rand512();
        m[0] = 1'b1;
        applyStimulus512(m);

        // Abort a run (even modulus, so invalid is set) with reset at cycle 300.
        m = rand512();
        m[0] = 1'b0;
        m[511] = 1'b1;
        @(negedge clk);
        start512 = 1'b1;
        mod512   = m;
        @(negedge clk);
        start512 = 1'b0;
        repeat (299) @(negedge clk);
        checkOutput("pre_abort_invalid", 512'(inv512), 512'(1));
        resetn = 1'b0;
        #1;
        checkOutput("abort_busy", 512'(busy512), 512'(0));
        checkOutput("abort_done", 512'(done512), 512'(0));
        checkOutput("abort_invalid", 512'(inv512), 512'(0));
        checkOutput("abort_rmodm", rm512, '0);
        checkOutput("abort_rsq", rr512, '0);
        checkOutput("abort_rmodm8", 512'(rm8), '0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus8(8'd13, 1'b0);
        applyStimulus512(512'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
